frame_config_ctrl: RTL
======================

FRAME_CONFIG_CTRL -- requirements
Module: frame_config_ctrl

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20: number of frame strobes per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32: frame data bits per tile row.
REQ-003 SHALL have parameter NumRows, default 4: tile rows in the column.
REQ-004 SHALL have port CLK, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, width 1: reset, synchronous and active-high.
REQ-006 SHALL have port s_data, input, width 32: configuration word stream.
REQ-007 SHALL have port s_valid, input, width 1: s_data valid.
REQ-008 SHALL have port s_ready, output, width 1: word accepted when s_valid && s_ready at a rising edge.
REQ-009 SHALL have port FrameData, output, width NumRows*FrameBitsPerRow: frame bits driven to the column.
REQ-010 SHALL have port FrameStrobe, output, width MaxFramesPerCol: one-hot frame write strobe.
REQ-011 SHALL have port busy, output, width 1: high when state != IDLE.
REQ-012 SHALL have port frame_done, output, width 1: one-cycle pulse per completed strobe.
REQ-013 SHALL have port err, output, width 1: sticky protocol error flag.
REQ-014 SHALL have port frames_written, output, width 16: count of strobes issued.

Function
REQ-015 SHALL implement states IDLE, DATA, DISCARD, STROBE.
REQ-016 IDLE: s_ready=1; an accepted word with s_data[31:24]==8'hFA is a header; frame_addr=s_data[4:0], latched.
REQ-017 Header with frame_addr < MaxFramesPerCol SHALL go to DATA with row counter cleared to 0.
REQ-018 Header with frame_addr >= MaxFramesPerCol SHALL set err and go to DISCARD with row counter cleared to 0.
REQ-019 Accepted word in IDLE with s_data[31:24] != 8'hFA SHALL be dropped, set err, and leave the state at IDLE.
REQ-020 DATA: s_ready=1; accepted word i (0-based) SHALL be written to FrameData[i*FrameBitsPerRow +: FrameBitsPerRow] (low FrameBitsPerRow bits of s_data).
REQ-021 Accepted word with row counter == NumRows-1 SHALL cause the transition to STROBE on the same edge.
REQ-022 DISCARD: s_ready=1; it SHALL accept and drop exactly NumRows words, then return to IDLE; FrameData is not modified and no strobe is issued.
REQ-023 STROBE: s_ready=0; FrameStrobe[frame_addr]=1 for exactly one cycle, all other bits 0; frame_done=1 in the same cycle; next state IDLE.
REQ-024 FrameStrobe SHALL be all-zero in every state other than STROBE.
REQ-025 FrameData SHALL hold its value from STROBE until overwritten row by row by the next valid frame.
REQ-026 frames_written SHALL increment by 1 on each STROBE cycle and wrap from 16'hFFFF to 0.
REQ-027 s_valid low SHALL stall any state except STROBE without a state change; there is no timeout.
REQ-028 Latency: the strobe SHALL occur exactly 1 cycle after the edge that accepts the last data word; minimum per frame is NumRows+2 cycles.
REQ-029 err SHALL remain set until RST; it SHALL not block subsequent valid frames.

Reset
REQ-030 RST high at a rising edge SHALL force the state to IDLE, FrameData=0, FrameStrobe=0, frame_done=0, err=0, frames_written=0, row counter=0, busy=0.
REQ-031 RST SHALL override any in-progress frame, including STROBE; an aborted frame SHALL produce no strobe after reset.
REQ-032 s_ready SHALL be 0 during a cycle with RST high and 1 in the first cycle after RST deasserts.

Verification
REQ-033 Header 32'hFA000003, then words 11111111, 22222222, 33333333, 44444444 back-to-back -> FrameData=32'h44444444_33333333_22222222_11111111, FrameStrobe=20'h00008 for one cycle, frame_done pulse, frames_written=1.
REQ-034 Header 32'hFA000015 (addr 21), then 4 words -> err=1, FrameStrobe stays 0, FrameData unchanged, state IDLE after the 4th word; the next valid frame to addr 0 -> FrameStrobe=20'h00001.
REQ-035 Word 32'h12345678 in IDLE -> dropped, err=1, busy=0; a subsequent valid frame completes normally.
REQ-036 Valid frame to addr 19 with s_valid toggled 0/1 on alternating cycles -> identical FrameData and FrameStrobe=20'h80000; s_ready=0 only in the STROBE cycle.
REQ-037 RST asserted after the 2nd data word -> all outputs at reset values and no strobe is ever issued for that frame.
REQ-038 65536 valid frames issued -> frames_written wraps to 0 on the last strobe.

Source files
------------

// File: rtl/frame_config_ctrl.sv
// Column configuration controller: collects a header plus NumRows data words from a
// valid/ready stream into FrameData, then pulses the one-hot strobe for the addressed frame.
module frame_config_ctrl #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [31:0]                        s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               err,
    output logic [15:0]                        frames_written
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DISCARD,
        STROBE
    } state_e;

    state_e                             state_q, state_d;
    logic [RowW-1:0]                    rowCnt_q, rowCnt_d;
    logic [4:0]                         frameAddr_q, frameAddr_d;
    logic                               err_q, err_d;
    logic [NumRows*FrameBitsPerRow-1:0] frameData_q, frameData_d;
    logic [15:0]                        framesWritten_q, framesWritten_d;

    logic accept;
    logic isHeader;
    logic addrOk;
    logic lastRow;

    // Ready is withheld while in reset so nothing is handshaken during that cycle.
    assign s_ready  = !RST && (state_q != STROBE);
    assign accept   = s_valid && s_ready;
    assign isHeader = (s_data[31:24] == 8'hFA);
    assign addrOk   = (32'(s_data[4:0]) < 32'(MaxFramesPerCol));
    assign lastRow  = (rowCnt_q == RowW'(NumRows - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= IDLE;
            rowCnt_q        <= '0;
            frameAddr_q     <= '0;
            err_q           <= 1'b0;
            frameData_q     <= '0;
            framesWritten_q <= '0;
        end else begin
            state_q         <= state_d;
            rowCnt_q        <= rowCnt_d;
            frameAddr_q     <= frameAddr_d;
            err_q           <= err_d;
            frameData_q     <= frameData_d;
            framesWritten_q <= framesWritten_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rowCnt_d        = rowCnt_q;
        frameAddr_d     = frameAddr_q;
        err_d           = err_q;
        frameData_d     = frameData_q;
        framesWritten_d = framesWritten_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (isHeader) begin
                        frameAddr_d = s_data[4:0];
                        rowCnt_d    = '0;
                        if (addrOk) begin
                            state_d = DATA;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    frameData_d[int'(rowCnt_q)*FrameBitsPerRow +: FrameBitsPerRow] =
                        s_data[FrameBitsPerRow-1:0];
                    if (lastRow) begin
                        rowCnt_d = '0;
                        state_d  = STROBE;
                    end else begin
                        rowCnt_d = rowCnt_q + 1'b1;
                    end
                end
            end
            // An out-of-range header still owns its payload words; swallow them.
            DISCARD: begin
                if (accept) begin
                    if (lastRow) begin
                        rowCnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        rowCnt_d = rowCnt_q + 1'b1;
                    end
                end
            end
            STROBE: begin
                framesWritten_d = framesWritten_q + 16'd1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        FrameStrobe = '0;
        if (state_q == STROBE) begin
            for (int i = 0; i < MaxFramesPerCol; i++) begin
                FrameStrobe[i] = (frameAddr_q == 5'(i));
            end
        end
    end

    assign frame_done     = (state_q == STROBE);
    assign busy           = (state_q != IDLE);
    assign err            = err_q;
    assign FrameData      = frameData_q;
    assign frames_written = framesWritten_q;

endmodule
